// File: rtl/serializer.sv
// Parallel-to-serial converter. Takes one WIDTH-bit word and a bit count, then
// shifts the selected bits out MSB first, one per clock, with a valid strobe.
// Handshake: a request (data_val_i=1) is sampled only on an edge where busy_o
// is 0; while busy_o is 1 the request and data_i are ignored. An accepted word
// produces ser_data_val_o=1 for exactly len consecutive cycles starting one
// cycle after the accepting edge, and busy_o mirrors ser_data_val_o.
module serializer #(
  parameter int WIDTH = 16,
  parameter int MOD_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [MOD_W-1:0] data_mod_i,
  input  logic             data_val_i,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic             busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [MOD_W-1:0] cnt_q, cnt_d;

  // Length minus one. data_mod_i==0 means WIDTH, and 0-1 wraps to all ones,
  // which is exactly WIDTH-1 because WIDTH is a power of two.
  logic [MOD_W-1:0] len_m1;
  logic             len_legal;
  logic             accept;

  assign len_m1    = data_mod_i - MOD_W'(1);
  assign len_legal = (data_mod_i != MOD_W'(1)) && (data_mod_i != MOD_W'(2));
  assign accept    = data_val_i && len_legal;

  // State register plus shift register and bit counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: load on an accepted request, shift and count while sending.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          shreg_d = data_i;
          cnt_d   = len_m1;
        end
      end
      SEND: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - MOD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from flops, so they drop the moment reset asserts
  // and the data line is held at 0 whenever nothing is being sent.
  always_comb begin
    ser_data_val_o = 1'b0;
    ser_data_o     = 1'b0;
    busy_o         = 1'b0;
    if (state_q == SEND) begin
      ser_data_val_o = 1'b1;
      ser_data_o     = shreg_q[WIDTH-1];
      busy_o         = 1'b1;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer. The reference model is a queue of bits still owed on
// the serial line: an accepted word appends its len bits, each clock removes
// one, and the line is busy exactly while the queue is non-empty.
module tb_serializer;

  localparam int WIDTH = 16;
  localparam int MOD_W = $clog2(WIDTH);

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data;
  logic [MOD_W-1:0] data_mod;
  logic             data_val;
  logic             ser_data;
  logic             ser_data_val;
  logic             busy;

  int total = 0;
  int bad   = 0;

  logic [0:0]  exp_q[$];
  logic [31:0] rx_word;
  int          rx_n;

  serializer #(.WIDTH(WIDTH), .MOD_W(MOD_W)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .data_i         (data),
    .data_mod_i     (data_mod),
    .data_val_i     (data_val),
    .ser_data_o     (ser_data),
    .ser_data_val_o (ser_data_val),
    .busy_o         (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the three outputs against the model's view of the current cycle.
  task automatic check_outputs(input string tag);
    logic ev;
    logic ed;
    ev = (exp_q.size() != 0);
    ed = ev ? exp_q[0][0] : 1'b0;
    chk({tag, "_val"},  {31'd0, ser_data_val}, {31'd0, ev});
    chk({tag, "_data"}, {31'd0, ser_data},     {31'd0, ed});
    chk({tag, "_busy"}, {31'd0, busy},         {31'd0, ev});
    if (ser_data_val === 1'b1) begin
      rx_word = {rx_word[30:0], ser_data};
      rx_n++;
    end
  endtask

  task automatic rx_clear();
    rx_word = '0;
    rx_n    = 0;
  endtask

  // One clock: drive at the negedge, advance the model at the posedge,
  // check at the following negedge.
  task automatic tick(input logic v, input logic [WIDTH-1:0] d, input logic [MOD_W-1:0] m,
                      input string tag);
    int len;
    data_val = v;
    data     = d;
    data_mod = m;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (v) begin
      len = (m == 0) ? WIDTH : int'(m);
      if (len > 2) begin
        for (int k = 0; k < len; k++) exp_q.push_back(d[WIDTH-1-k]);
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, WIDTH'($urandom), MOD_W'($urandom), tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    data_val = 1'b0;
    data     = '0;
    data_mod = '0;
    rx_clear();

    // Reset held for three clocks while the request line toggles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_val = i[0];
      data     = 16'hFFFF;
      #1;
      chk("rst_val",  {31'd0, ser_data_val}, 32'd0);
      chk("rst_data", {31'd0, ser_data},     32'd0);
      chk("rst_busy", {31'd0, busy},         32'd0);
    end
    @(negedge clk);
    data_val = 1'b0;
    rst_n    = 1'b1;
    idle(2, "post_rst");

    // Full 16-bit word.
    rx_clear();
    tick(1'b1, 16'hA5C3, 4'd0, "full");
    idle(17, "full");
    chk("full_count", rx_n, 32'd16);
    chk("full_word",  rx_word, 32'h0000A5C3);

    // Short word of 3 bits.
    rx_clear();
    tick(1'b1, 16'hE000, 4'd3, "short");
    idle(5, "short");
    chk("short_count", rx_n, 32'd3);
    chk("short_bits",  rx_word, 32'h7);

    // Illegal lengths are dropped, then a 4-bit word goes through.
    rx_clear();
    tick(1'b1, 16'hFFFF, 4'd1, "illegal1");
    tick(1'b1, 16'hFFFF, 4'd2, "illegal2");
    idle(3, "illegal");
    chk("illegal_count", rx_n, 32'd0);
    tick(1'b1, 16'h9FFF, 4'd4, "mod4");
    idle(6, "mod4");
    chk("mod4_count", rx_n, 32'd4);
    chk("mod4_bits",  rx_word, 32'h9);

    // Request held high: the second word waits until the first has left.
    rx_clear();
    tick(1'b1, 16'hFFFF, 4'd0, "b2b");
    for (int i = 0; i < 17; i++) tick(1'b1, 16'h0000, 4'd0, "b2b");
    idle(20, "b2b");
    chk("b2b_count", rx_n, 32'd32);
    chk("b2b_words", rx_word, 32'hFFFF0000);

    // Reset in the middle of a word.
    rx_clear();
    tick(1'b1, 16'h1234, 4'd0, "mid");
    idle(4, "mid");
    chk("mid_count", rx_n, 32'd5);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_val",  {31'd0, ser_data_val}, 32'd0);
    chk("mid_rst_data", {31'd0, ser_data},     32'd0);
    chk("mid_rst_busy", {31'd0, busy},         32'd0);
    tick(1'b1, 16'hFFFF, 4'd0, "mid_rst");
    tick(1'b0, 16'hFFFF, 4'd0, "mid_rst");
    rst_n = 1'b1;
    idle(2, "mid_rel");
    rx_clear();
    tick(1'b1, 16'h1234, 4'd0, "loop");
    idle(18, "loop");
    chk("loop_count", rx_n, 32'd16);
    chk("loop_word",  rx_word, 32'h00001234);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 3) == 0), WIDTH'($urandom), MOD_W'($urandom_range(0, 15)), "rand");
    end
    idle(20, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
